// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding, default width and constant helpers for seq_divider
package seq_divider_pkg;
  localparam int DEFAULT_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  function automatic logic [127:0] most_neg(input int w);
    return 128'(1) << (w - 1);
  endfunction
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done request and result bundle between a requester and seq_divider
interface seq_divider_if import seq_divider_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic start;
  logic is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic of;
  logic dz;
  modport master (output start, is_signed, a, b, input busy, done, quotient, remainder, of, dz);
  modport slave (input start, is_signed, a, b, output busy, done, quotient, remainder, of, dz);
endinterface

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one restoring-division step (shift in a dividend bit, trial-subtract the divisor)
module seq_divider_div_step import seq_divider_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  // the remainder never reaches the divisor, so the shifted value always fits back in WIDTH+1 bits
  always_comb begin
    q_bit = {rem_in, bit_in} >= {2'b00, dvs};
    rem_out = q_bit ? (WIDTH+1)'({rem_in, bit_in} - {2'b00, dvs}) : (WIDTH+1)'({rem_in, bit_in});
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock; SEQ_DIVIDER_EARLY_OUT_EN skips ITER when the quotient is trivially zero
module seq_divider import seq_divider_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
  input logic clk,
  input logic rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(most_neg(WIDTH));
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, mag_a, mag_b, dvd, dvs;
  logic [WIDTH:0] rem, rem_step;
  logic sgn_r, sign_q, sign_r, q_bit, zero_b, ovf, early, accept;
  assign accept = (state == IDLE || state == DONE) && bus.start;
  assign mag_a = sgn_r && a_r[WIDTH-1] ? -a_r : a_r;
  assign mag_b = sgn_r && b_r[WIDTH-1] ? -b_r : b_r;
  assign zero_b = b_r == '0;
  assign ovf = sgn_r && a_r == MIN_NEG && b_r == '1;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  assign early = zero_b || mag_b > mag_a;
`else
  assign early = 1'b0;
`endif
  seq_divider_div_step #(.WIDTH(WIDTH)) div_step (
    .rem_in(rem),
    .bit_in(dvd[WIDTH-1]),
    .dvs(dvs),
    .rem_out(rem_step),
    .q_bit(q_bit)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // sequencing and status outputs; DONE+start chains straight into PREP
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = bus.start ? PREP : IDLE;
      PREP:       state_n = early ? FIX : ITER;
      ITER:       state_n = cnt == '0 ? FIX : ITER;
      FIX:        state_n = DONE;
      default:    state_n = IDLE;
    endcase
    bus.busy = state == PREP || state == ITER || state == FIX;
    bus.done = state == DONE;
  end
  // operand capture, magnitude prep and the shift/subtract loop; dvd doubles as the quotient register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      sgn_r <= 1'b0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      if (accept) begin
        a_r <= bus.a;
        b_r <= bus.b;
        sgn_r <= bus.is_signed;
      end
      if (state == PREP) begin
        dvd <= early ? '0 : mag_a;
        dvs <= mag_b;
        rem <= early ? {1'b0, mag_a} : '0;
        cnt <= CW'(WIDTH - 1);
        sign_q <= sgn_r && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
        sign_r <= sgn_r && a_r[WIDTH-1];
      end
      if (state == ITER) begin
        rem <= rem_step;
        dvd <= {dvd[WIDTH-2:0], q_bit};
        cnt <= cnt - 1'b1;
      end
    end
  // sign fix-up and special cases, registered only on the FIX->DONE edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.of <= 1'b0;
      bus.dz <= 1'b0;
    end else if (state == FIX) begin
      bus.quotient <= zero_b ? '1 : ovf ? MIN_NEG : sign_q ? -dvd : dvd;
      bus.remainder <= zero_b ? a_r : ovf ? '0 : sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
      bus.of <= ovf;
      bus.dz <= zero_b;
    end
endmodule
